// File: rtl/cfg_miss_mem.sv
// cfg_miss_mem: behavioural I/D memory model with optional direct-mapped miss injection.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_addr/i_rd/i_trd          instruction fetch request -> i_rd_data, i_miss, i_segfault
//   d_addr/d_wr_data/d_rd/d_wr/d_trd  data request -> d_rd_data, d_miss, d_segfault
//   flush                      invalidate both tag arrays and abort fills
//   i_busy/d_busy              fill in progress on that port
//   i_fill_trd/d_fill_trd      thread that started the current fill
//   *_hit_cnt/*_miss_cnt       saturating hit/miss statistics

// One port's direct-mapped tag array, fill FSM and statistics.
module cfg_miss_port #(
  parameter int MISS_MODE = 1,
  parameter int LINES     = 16,
  parameter int LA_W      = 28,
  parameter int MISS_LAT  = 8,
  parameter int TRD_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req,
  input  logic             rd,
  input  logic [LA_W-1:0]  line_addr,
  input  logic [TRD_W-1:0] trd,
  output logic             hit,
  output logic             miss,
  output logic             busy,
  output logic [TRD_W-1:0] fill_trd,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
);
  localparam int IB = $clog2(LINES);
  localparam int TW = LA_W - IB;
  localparam int CW = $clog2(MISS_LAT + 1);
  typedef enum logic {IDLE, FILL} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IB-1:0]           idx, idx_q, idx_d;
  logic [TW-1:0]           tag, tag_q, tag_d;
  logic [TRD_W-1:0]        trd_q, trd_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [LINES-1:0][TW-1:0] tags_q, tags_d;
  logic [31:0]             hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                    start;
  assign idx      = line_addr[IB-1:0];
  assign tag      = line_addr[LA_W-1:IB];
  assign busy     = state_q == FILL;
  assign fill_trd = trd_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  always_comb begin
    hit     = req && (MISS_MODE == 0 || (state_q == IDLE && valid_q[idx] && tags_q[idx] == tag));
    miss    = req && !hit;
    // A fill requested in a flush cycle is dropped along with the tags.
    start   = miss && state_q == IDLE && !flush;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    trd_d   = trd_q;
    valid_d = valid_q;
    tags_d  = tags_q;
    if (state_q == FILL) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d        = IDLE;
        valid_d[idx_q] = 1'b1;
        tags_d[idx_q]  = tag_q;
      end
    end else if (start) begin
      trd_d = trd;
      // A one-cycle fill completes on the missing edge itself and never shows busy.
      if (MISS_LAT == 1) begin
        valid_d[idx] = 1'b1;
        tags_d[idx]  = tag;
      end else begin
        state_d = FILL;
        cnt_d   = CW'(MISS_LAT - 1);
        idx_d   = idx;
        tag_d   = tag;
      end
    end
    if (flush) begin
      state_d = IDLE;
      valid_d = '0;
    end
    hit_cnt_d  = hit_cnt_q + 32'(rd && hit && hit_cnt_q != '1);
    miss_cnt_d = miss_cnt_q + 32'(miss && miss_cnt_q != '1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      trd_q      <= '0;
      valid_q    <= '0;
      tags_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      trd_q      <= trd_d;
      valid_q    <= valid_d;
      tags_q     <= tags_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule

module cfg_miss_mem #(
  parameter int    MISS_MODE  = 1,
  parameter int    MEM_WORDS  = 16384,
  parameter int    LINES      = 16,
  parameter int    LINE_WORDS = 4,
  parameter int    MISS_LAT   = 8,
  parameter int    TRD_W      = 3,
  parameter string INIT_FILE  = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_addr,
  input  logic             i_rd,
  input  logic [TRD_W-1:0] i_trd,
  output logic [31:0]      i_rd_data,
  output logic             i_miss,
  output logic             i_segfault,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wr_data,
  input  logic             d_rd,
  input  logic             d_wr,
  input  logic [TRD_W-1:0] d_trd,
  output logic [31:0]      d_rd_data,
  output logic             d_miss,
  output logic             d_segfault,
  input  logic             flush,
  output logic             i_busy,
  output logic             d_busy,
  output logic [TRD_W-1:0] i_fill_trd,
  output logic [TRD_W-1:0] d_fill_trd,
  output logic [31:0]      i_hit_cnt,
  output logic [31:0]      i_miss_cnt,
  output logic [31:0]      d_hit_cnt,
  output logic [31:0]      d_miss_cnt
);
  localparam int AW   = $clog2(MEM_WORDS);
  localparam int OB   = $clog2(LINE_WORDS);
  localparam int LA_W = 30 - OB;
  logic [31:0]   mem_q [MEM_WORDS];
  logic          i_act, d_act, i_ok, d_ok, i_req, d_req, i_hit, d_hit, wr_en;
  logic [AW-1:0] i_widx, d_widx;
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_q[i] = '0;
  end
  always_comb begin
    // Requests are ignored while reset is held so every output reads 0.
    i_act      = rst_n && i_rd;
    d_act      = rst_n && (d_rd || d_wr);
    i_ok       = i_addr[1:0] == 2'b00 && (i_addr >> (AW + 2)) == 32'd0;
    d_ok       = d_addr[1:0] == 2'b00 && (d_addr >> (AW + 2)) == 32'd0 && !(d_rd && d_wr);
    i_segfault = i_act && !i_ok;
    d_segfault = d_act && !d_ok;
    i_req      = i_act && i_ok;
    d_req      = d_act && d_ok;
    i_widx     = i_addr[AW+1:2];
    d_widx     = d_addr[AW+1:2];
    i_rd_data  = i_hit ? mem_q[i_widx] : 32'd0;
    d_rd_data  = (d_hit && d_rd) ? mem_q[d_widx] : 32'd0;
    wr_en      = d_hit && d_wr;
  end
  // Synchronous write after the combinational reads gives read-before-write.
  always @(posedge clk) begin
    if (wr_en) mem_q[d_widx] <= d_wr_data;
  end
  cfg_miss_port #(
    .MISS_MODE(MISS_MODE), .LINES(LINES), .LA_W(LA_W), .MISS_LAT(MISS_LAT), .TRD_W(TRD_W)
  ) u_i (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(i_req), .rd(i_req),
    .line_addr(i_addr[31:2+OB]), .trd(i_trd), .hit(i_hit), .miss(i_miss), .busy(i_busy),
    .fill_trd(i_fill_trd), .hit_cnt(i_hit_cnt), .miss_cnt(i_miss_cnt)
  );
  cfg_miss_port #(
    .MISS_MODE(MISS_MODE), .LINES(LINES), .LA_W(LA_W), .MISS_LAT(MISS_LAT), .TRD_W(TRD_W)
  ) u_d (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(d_req), .rd(d_req && d_rd),
    .line_addr(d_addr[31:2+OB]), .trd(d_trd), .hit(d_hit), .miss(d_miss), .busy(d_busy),
    .fill_trd(d_fill_trd), .hit_cnt(d_hit_cnt), .miss_cnt(d_miss_cnt)
  );
endmodule

// File: tb/tb_cfg_miss_mem.sv
// tb_cfg_miss_mem: directed bench for cfg_miss_mem in always-hit, 8-cycle and 1-cycle fill setups.
module tb_cfg_miss_mem;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr, d_addr, d_wr_data;
  logic        i_rd, d_rd, d_wr, flush;
  logic [2:0]  i_trd, d_trd;
  logic [31:0] i_rd_data [3], d_rd_data [3];
  logic [31:0] i_hit_cnt [3], i_miss_cnt [3], d_hit_cnt [3], d_miss_cnt [3];
  logic        i_miss [3], i_seg [3], d_miss [3], d_seg [3], i_busy [3], d_busy [3];
  logic [2:0]  i_fill_trd [3], d_fill_trd [3];
  int          n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  // Instance 0: always hit; 1: MISS_LAT=8; 2: MISS_LAT=1. All share the same stimulus.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    cfg_miss_mem #(
      .MISS_MODE(k == 0 ? 0 : 1), .MEM_WORDS(1024), .LINES(16), .LINE_WORDS(4),
      .MISS_LAT(k == 2 ? 1 : 8), .TRD_W(3)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
      .i_rd_data(i_rd_data[k]), .i_miss(i_miss[k]), .i_segfault(i_seg[k]),
      .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
      .d_rd_data(d_rd_data[k]), .d_miss(d_miss[k]), .d_segfault(d_seg[k]),
      .flush(flush), .i_busy(i_busy[k]), .d_busy(d_busy[k]),
      .i_fill_trd(i_fill_trd[k]), .d_fill_trd(d_fill_trd[k]),
      .i_hit_cnt(i_hit_cnt[k]), .i_miss_cnt(i_miss_cnt[k]),
      .d_hit_cnt(d_hit_cnt[k]), .d_miss_cnt(d_miss_cnt[k])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    i_rd = 1'b0;
    d_rd = 1'b0;
    d_wr = 1'b0;
    flush = 1'b0;
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      idle();
    end
  endtask
  task automatic do_reset();
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic dload(input logic [31:0] a);
    tick();
    idle();
    d_rd = 1'b1;
    d_addr = a;
    #1;
  endtask
  task automatic dstore(input logic [31:0] a, input logic [31:0] v);
    tick();
    idle();
    d_wr = 1'b1;
    d_addr = a;
    d_wr_data = v;
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    i_addr = '0;
    d_addr = '0;
    d_wr_data = '0;
    i_trd = '0;
    d_trd = '0;
    tick();
    tick();
    #1;
    check("rst u1 i_busy", i_busy[1], 0);
    check("rst u1 d_busy", d_busy[1], 0);
    check("rst u1 i_fill_trd", i_fill_trd[1], 0);
    check("rst u0 i_hit_cnt", i_hit_cnt[0], 0);
    check("rst u1 d_miss_cnt", d_miss_cnt[1], 0);
    check("rst u1 i_rd_data", i_rd_data[1], 0);
    rst_n = 1'b1;
    // Always-hit mode; the same store misses in both miss-model instances.
    dstore(32'h10, 32'h1234_5678);
    check("A u0 store d_miss", d_miss[0], 0);
    check("A u2 store d_miss", d_miss[2], 1);
    check("A u1 store d_miss", d_miss[1], 1);
    tick();
    idle();
    i_rd = 1'b1;
    i_addr = 32'h10;
    d_rd = 1'b1;
    d_addr = 32'h10;
    #1;
    check("A u0 i_rd_data", i_rd_data[0], 32'h1234_5678);
    check("A u0 d_rd_data", d_rd_data[0], 32'h1234_5678);
    check("A u0 i_miss", i_miss[0], 0);
    check("A u0 d_miss", d_miss[0], 0);
    check("A u2 d_miss after lat1 fill", d_miss[2], 0);
    check("A u2 d_rd_data store-miss no write", d_rd_data[2], 0);
    check("A u1 d_miss during fill", d_miss[1], 1);
    tick();
    idle();
    #1;
    check("A u0 i_hit_cnt", i_hit_cnt[0], 1);
    check("A u0 d_hit_cnt", d_hit_cnt[0], 1);
    check("A u0 d_miss_cnt", d_miss_cnt[0], 0);
    check("A u0 d_busy", d_busy[0], 0);
    check("A u2 d_hit_cnt", d_hit_cnt[2], 1);
    check("A u2 d_miss_cnt", d_miss_cnt[2], 1);
    check("A u1 d_miss_cnt", d_miss_cnt[1], 2);
    check("A u1 d_hit_cnt", d_hit_cnt[1], 0);
    check("A idle u0 i_rd_data", i_rd_data[0], 0);
    do_reset();
    // Instruction fill with MISS_LAT=8.
    tick();
    idle();
    i_rd = 1'b1;
    i_addr = 32'h0;
    i_trd = 3'd5;
    #1;
    check("B u1 i_miss", i_miss[1], 1);
    check("B u1 i_rd_data on miss", i_rd_data[1], 0);
    check("B u1 i_busy miss cycle", i_busy[1], 0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      idle();
      #1;
      check($sformatf("B u1 i_busy N+%0d", c), i_busy[1], 1);
      if (c == 1) check("B u1 i_fill_trd", i_fill_trd[1], 5);
    end
    tick();
    i_rd = 1'b1;
    i_addr = 32'h4;
    i_trd = 3'd0;
    #1;
    check("B u1 retry i_miss", i_miss[1], 0);
    check("B u1 retry i_busy", i_busy[1], 0);
    tick();
    idle();
    #1;
    check("B u1 i_hit_cnt", i_hit_cnt[1], 1);
    check("B u1 i_miss_cnt", i_miss_cnt[1], 1);
    // Data tag conflict, write-allocate store, store after fill.
    dload(32'h0);
    check("C u1 load 0 first", d_miss[1], 1);
    idle_cycles(7);
    dload(32'h0);
    check("C u1 load 0 after fill", d_miss[1], 0);
    dload(32'h100);
    check("C u1 load 0x100 conflict", d_miss[1], 1);
    dstore(32'h100, 32'hDEAD_BEEF);
    check("C u1 store during fill", d_miss[1], 1);
    idle_cycles(6);
    dload(32'h100);
    check("C u1 load 0x100 hit", d_miss[1], 0);
    check("C u1 missed store not written", d_rd_data[1], 0);
    dstore(32'h100, 32'hDEAD_BEEF);
    check("C u1 store hit", d_miss[1], 0);
    dload(32'h100);
    check("C u1 load stored", d_rd_data[1], 32'hDEAD_BEEF);
    dload(32'h0);
    check("C u1 load 0 evicted", d_miss[1], 1);
    do_reset();
    // Segfaults.
    tick();
    idle();
    d_rd = 1'b1;
    d_addr = 32'h2;
    i_rd = 1'b1;
    i_addr = 32'h1000;
    #1;
    check("D u1 d_seg misaligned", d_seg[1], 1);
    check("D u1 d_miss misaligned", d_miss[1], 0);
    check("D u1 d_rd_data seg", d_rd_data[1], 0);
    check("D u1 i_seg range", i_seg[1], 1);
    check("D u1 i_miss range", i_miss[1], 0);
    check("D u0 i_seg range", i_seg[0], 1);
    check("D u0 i_rd_data seg", i_rd_data[0], 0);
    tick();
    idle();
    d_rd = 1'b1;
    d_wr = 1'b1;
    d_addr = 32'h0;
    #1;
    check("D u1 d_seg rd&wr", d_seg[1], 1);
    check("D u1 d_miss rd&wr", d_miss[1], 0);
    check("D u1 i_seg idle", i_seg[1], 0);
    tick();
    idle();
    #1;
    check("D u1 i_busy", i_busy[1], 0);
    check("D u1 d_busy", d_busy[1], 0);
    check("D u1 i_miss_cnt", i_miss_cnt[1], 0);
    check("D u1 d_miss_cnt", d_miss_cnt[1], 0);
    check("D u0 d_hit_cnt", d_hit_cnt[0], 0);
    check("D u1 d_seg idle", d_seg[1], 0);
    // Read-before-write in always-hit mode.
    dstore(32'h20, 32'h1111_1111);
    tick();
    idle();
    d_wr = 1'b1;
    d_addr = 32'h20;
    d_wr_data = 32'hA5A5_A5A5;
    i_rd = 1'b1;
    i_addr = 32'h20;
    #1;
    check("E u0 fetch old word", i_rd_data[0], 32'h1111_1111);
    tick();
    idle();
    i_rd = 1'b1;
    i_addr = 32'h20;
    #1;
    check("E u0 fetch new word", i_rd_data[0], 32'hA5A5_A5A5);
    do_reset();
    // Flush in fill-completion cycle, then reset mid-fill.
    dload(32'h40);
    check("F u1 load miss", d_miss[1], 1);
    idle_cycles(6);
    tick();
    idle();
    flush = 1'b1;
    #1;
    check("F u1 d_busy completion cycle", d_busy[1], 1);
    tick();
    idle();
    d_rd = 1'b1;
    d_addr = 32'h40;
    d_trd = 3'd6;
    #1;
    check("F u1 miss after flush", d_miss[1], 1);
    check("F u1 d_busy after flush", d_busy[1], 0);
    tick();
    idle();
    #1;
    check("F u1 d_busy refill", d_busy[1], 1);
    check("F u1 d_fill_trd", d_fill_trd[1], 6);
    check("F u1 d_miss_cnt", d_miss_cnt[1], 2);
    rst_n = 1'b0;
    tick();
    #1;
    check("F rst u1 d_busy", d_busy[1], 0);
    check("F rst u1 d_fill_trd", d_fill_trd[1], 0);
    check("F rst u1 d_miss_cnt", d_miss_cnt[1], 0);
    rst_n = 1'b1;
    d_trd = 3'd0;
    dload(32'h40);
    check("F u1 miss after reset", d_miss[1], 1);
    do_reset();
    // One-cycle fill: retry on the next cycle hits, busy never rises.
    tick();
    idle();
    i_rd = 1'b1;
    i_addr = 32'h8;
    #1;
    check("G u2 i_miss", i_miss[2], 1);
    tick();
    #1;
    check("G u2 i_busy", i_busy[2], 0);
    check("G u2 retry i_miss", i_miss[2], 0);
    tick();
    idle();
    #1;
    check("G u2 i_hit_cnt", i_hit_cnt[2], 1);
    check("G u2 i_miss_cnt", i_miss_cnt[2], 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
